// File: rtl/instr_fetch_if.sv
// Instruction fetch bus bundle: instruction-memory request/response channel,
// the decode-side valid/ready handshake and the redirect input.
// The master side is the fetch stage; the slave side is the surrounding core/memory.
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        id_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, instruction, instr_pc, instr_valid,
        input  imem_ack, imem_rvalid, imem_rdata, id_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instruction, instr_pc, instr_valid,
        output imem_ack, imem_rvalid, imem_rdata, id_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, keeps at most one request outstanding
// to a variable-latency instruction memory, and buffers returned words in a
// first-word-fall-through prefetch FIFO drained by decode. A redirect flushes
// the FIFO and restarts fetch at the word-aligned target.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [31:0]   WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t        state, state_nxt;
    logic [31:0]   pc, pc_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [31:0]   word_mem [FIFO_DEPTH];
    logic [31:0]   pc_mem   [FIFO_DEPTH];
    logic          empty, push, pop;

    // A redirect cancels both the decode pop and any word landing this cycle.
    assign empty     = (count == '0);
    assign pop       = !empty && bus.id_ready && !bus.redirect;
    assign push      = (state == WAIT) && bus.imem_rvalid && !bus.redirect;
    assign count_nxt = count + CW'(push) - CW'(pop);

    // Next-state and next-PC selection; the outstanding request counts as an occupied slot.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        if (bus.redirect) begin
            pc_nxt = bus.redirect_pc & WORD_MASK;
        end else if (push) begin
            pc_nxt = pc + 32'd4;
        end
        case (state)
            IDLE: begin
                if (!bus.redirect && (count < DEPTH_C)) state_nxt = REQ;
            end
            REQ: begin
                if (bus.redirect)      state_nxt = bus.imem_ack ? DROP : IDLE;
                else if (bus.imem_ack) state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.redirect)         state_nxt = bus.imem_rvalid ? IDLE : DROP;
                else if (bus.imem_rvalid) state_nxt = (count_nxt < DEPTH_C) ? REQ : IDLE;
            end
            DROP: begin
                // The in-flight response is the only thing left to swallow; a redirect here just moves the PC.
                if (bus.imem_rvalid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state: FSM, PC, FIFO occupancy and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc     <= RESET_PC & WORD_MASK;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (bus.redirect) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count <= count_nxt;
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // FIFO payload storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr] <= bus.imem_rdata;
            pc_mem[wr_ptr]   <= pc;
        end
    end

    assign bus.imem_req    = (state == REQ);
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = !empty;
    assign bus.instruction = empty ? 32'h0 : word_mem[rd_ptr];
    assign bus.instr_pc    = empty ? 32'h0 : pc_mem[rd_ptr];
endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: a variable-latency imem responder, a scoreboard of
// expected fetch addresses, and a monitor that checks every word decode accepts.
module tb_instr_fetch;
    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] RPC = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    instr_fetch_if bus();

    instr_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q   [$];
    logic [31:0] req_log [$];

    int          ack_dly   = 0;
    int          rv_dly    = 1;
    int          rsp_phase = 0;
    int          rsp_cnt   = 0;
    logic [31:0] rsp_addr  = 32'h0;

    logic        rv_rdr_arm  = 1'b0;
    logic [31:0] rv_rdr_addr = 32'h0;
    logic [31:0] rv_rdr_tgt  = 32'h0;

    logic        main_rdr    = 1'b0;
    logic [31:0] main_rdr_pc = 32'h0;
    logic        rsp_rdr     = 1'b0;
    logic [31:0] rsp_rdr_pc  = 32'h0;

    assign bus.redirect    = main_rdr | rsp_rdr;
    assign bus.redirect_pc = rsp_rdr ? rsp_rdr_pc : main_rdr_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int max);
        int i = 0;
        while (exp_q.size() > 0 && i < max) begin
            cyc();
            i++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic do_redirect(input logic [31:0] tgt, input logic rdy);
        main_rdr     = 1'b1;
        main_rdr_pc  = tgt;
        bus.id_ready = rdy;
        exp_q.delete();
        cyc();
        main_rdr = 1'b0;
        req_log.delete();
    endtask

    // imem responder: ack after ack_dly cycles, rvalid rv_dly cycles after ack.
    initial begin
        bus.imem_ack    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            bus.imem_ack    = 1'b0;
            bus.imem_rvalid = 1'b0;
            rsp_rdr         = 1'b0;
            if (!rst_n) begin
                rsp_phase = 0;
            end else if (rsp_phase == 2) begin
                check("req_low_while_waiting", {31'h0, bus.imem_req}, 32'h0);
                if (rsp_cnt == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = rsp_addr ^ K;
                    rsp_phase       = 0;
                    if (rv_rdr_arm && rsp_addr == rv_rdr_addr) begin
                        rsp_rdr    = 1'b1;
                        rsp_rdr_pc = rv_rdr_tgt;
                        rv_rdr_arm = 1'b0;
                    end
                end else begin
                    rsp_cnt--;
                end
            end else begin
                if (rsp_phase == 0 && bus.imem_req) begin
                    rsp_addr = bus.imem_addr;
                    req_log.push_back(rsp_addr);
                    rsp_cnt   = ack_dly;
                    rsp_phase = 1;
                end else if (rsp_phase == 1) begin
                    if (!bus.imem_req) rsp_phase = 0;
                    else check("addr_stable", bus.imem_addr, rsp_addr);
                end
                if (rsp_phase == 1) begin
                    if (rsp_cnt == 0) begin
                        bus.imem_ack = 1'b1;
                        rsp_phase    = 2;
                        rsp_cnt      = rv_dly - 1;
                    end else begin
                        rsp_cnt--;
                    end
                end
            end
        end
    end

    // Monitor: every word decode accepts must match the next expected address and its data.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && bus.instr_valid && bus.id_ready && !bus.redirect && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("instr_pc", bus.instr_pc, e);
                check("instruction", bus.instruction, e ^ K);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int i;
        logic [31:0] a;
        rst_n        = 1'b1;
        bus.id_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        repeat (2) cyc();

        check("rst_imem_req",    {31'h0, bus.imem_req},    32'h0);
        check("rst_instr_valid", {31'h0, bus.instr_valid}, 32'h0);
        check("rst_instruction", bus.instruction, 32'h0);
        check("rst_instr_pc",    bus.instr_pc,    32'h0);
        check("rst_imem_addr",   bus.imem_addr,   RPC);

        // 1: streaming from the reset PC, including the 32-bit wrap
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        for (a = 32'h4; a <= 32'h14; a += 4) exp_q.push_back(a);
        bus.id_ready = 1'b1;
        rst_n        = 1'b1;
        wait_drain("t1", 200);

        // 2: decode stalled, FIFO fills to depth and fetch stops
        do_redirect(32'h0, 1'b0);
        repeat (40) cyc();
        check("t2_req_count", req_log.size(), 4);
        check("t2_last_req", (req_log.size() == 4) ? req_log[3] : 32'hDEAD_BEEF, 32'hC);
        check("t2_imem_req", {31'h0, bus.imem_req}, 32'h0);
        check("t2_valid", {31'h0, bus.instr_valid}, 32'h1);
        check("t2_head_pc", bus.instr_pc, 32'h0);
        check("t2_head_word", bus.instruction, K);
        for (a = 32'h0; a <= 32'h14; a += 4) exp_q.push_back(a);
        bus.id_ready = 1'b1;
        wait_drain("t2", 200);

        // 3: slow ack and slow data
        ack_dly = 3;
        rv_dly  = 5;
        do_redirect(32'h8, 1'b1);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        wait_drain("t3", 200);
        check("t3_first_req", (req_log.size() > 0) ? req_log[0] : 32'hDEAD_BEEF, 32'h8);

        // 4: redirect while waiting for the word at 0x8
        do_redirect(32'h8, 1'b1);
        i = 0;
        while (!(rsp_phase == 2 && rsp_addr == 32'h8) && i < 40) begin
            cyc();
            i++;
        end
        check("t4_reached_wait", {31'h0, rsp_phase == 2 && rsp_addr == 32'h8}, 32'h1);
        cyc();
        main_rdr    = 1'b1;
        main_rdr_pc = 32'h0000_0103;
        cyc();
        main_rdr = 1'b0;
        check("t4_flushed", {31'h0, bus.instr_valid}, 32'h0);
        req_log.delete();
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        wait_drain("t4", 200);
        check("t4_first_req", (req_log.size() > 0) ? req_log[0] : 32'hDEAD_BEEF, 32'h100);

        // 5a: redirect coincident with rvalid of 0x204
        ack_dly = 0;
        rv_dly  = 1;
        do_redirect(32'h200, 1'b0);
        rv_rdr_addr = 32'h204;
        rv_rdr_tgt  = 32'h300;
        rv_rdr_arm  = 1'b1;
        i = 0;
        while (rv_rdr_arm && i < 50) begin
            cyc();
            i++;
        end
        check("t5_rdr_fired", {31'h0, rv_rdr_arm}, 32'h0);
        repeat (20) cyc();
        check("t5a_valid", {31'h0, bus.instr_valid}, 32'h1);
        check("t5a_head_pc", bus.instr_pc, 32'h300);
        check("t5a_head_word", bus.instruction, 32'h300 ^ K);

        // 5b: redirect coincident with a pop of the 0x300 word
        do_redirect(32'h400, 1'b1);
        check("t5b_flushed", {31'h0, bus.instr_valid}, 32'h0);
        exp_q.push_back(32'h400);
        exp_q.push_back(32'h404);
        exp_q.push_back(32'h408);
        wait_drain("t5b", 200);

        // 6: asynchronous reset in the middle of a wait, FIFO holding data
        rv_dly = 4;
        do_redirect(32'h500, 1'b0);
        i = 0;
        while (!(bus.instr_valid && rsp_phase == 2) && i < 60) begin
            cyc();
            i++;
        end
        check("t6_reached_wait", {31'h0, bus.instr_valid && rsp_phase == 2}, 32'h1);
        cyc();
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_imem_req",    {31'h0, bus.imem_req},    32'h0);
        check("t6_instr_valid", {31'h0, bus.instr_valid}, 32'h0);
        check("t6_instruction", bus.instruction, 32'h0);
        check("t6_instr_pc",    bus.instr_pc,    32'h0);
        check("t6_imem_addr",   bus.imem_addr,   RPC);
        exp_q.delete();
        repeat (2) cyc();
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        rv_dly       = 1;
        bus.id_ready = 1'b1;
        rst_n        = 1'b1;
        wait_drain("t6", 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
